hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard and stall controller for the 5-stage RISC-V core, next generation of the load-use detector.
//  Detects load-use hazards between ID/EX and IF/ID and inserts LOAD_LAT bubbles for multi-cycle load data.
//  Freezes the whole pipeline while the data memory is busy and flushes IF/ID on a taken branch.
//  Sits beside the ID stage; drives the PC, IF/ID and ID/EX control-mux enables.
// PARAMETERS
//  REG_AW    5   register-address width
//  LOAD_LAT  1   bubbles per load-use hazard (>=1; 1 = classic single-bubble stall)
//  CNT_W     16  width of the statistics counters
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  idex_memread   in   1        instruction in EX is a load
//  idex_rd        in   REG_AW   destination register of the instruction in EX
//  ifid_rs1       in   REG_AW   rs1 of the instruction in ID
//  ifid_rs2       in   REG_AW   rs2 of the instruction in ID
//  ifid_use_rs1   in   1        ID instruction reads rs1
//  ifid_use_rs2   in   1        ID instruction reads rs2
//  branch_taken   in   1        taken branch/jump resolved in EX
//  mem_busy       in   1        data memory not ready this cycle
//  pc_write       out  1        PC update enable
//  ifid_write     out  1        IF/ID register write enable
//  idex_bubble    out  1        zero ID/EX control signals (insert NOP)
//  ifid_flush     out  1        clear IF/ID to NOP
//  pipe_freeze    out  1        hold ID/EX, EX/MEM and MEM/WB
//  stall          out  1        ~pc_write, for debug and legacy use
//  lu_stall_cnt   out  CNT_W    load-use bubble cycles (saturating)
//  mem_stall_cnt  out  CNT_W    memory-freeze cycles (saturating)
// BEHAVIOUR
//  - lu_hit = idex_memread & (idex_rd!=0) & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd)); x0 never hazards.
//  - FSM states: RUN, LU_WAIT, FREEZE; lu_cnt is a down-counter of width clog2(LOAD_LAT)+1.
//  - Priority each cycle: mem_busy > branch_taken > lu_hit/LU_WAIT > normal.
//  - RUN, no event: pc_write=ifid_write=1; all other outputs 0.
//  - RUN, lu_hit: outputs combinational in the same cycle: pc_write=ifid_write=0, idex_bubble=1.
//      Load lu_cnt=LOAD_LAT-1. Go to LU_WAIT if lu_cnt!=0; otherwise stay in RUN.
//  - LU_WAIT: stall as above, decrement lu_cnt; return to RUN in the cycle lu_cnt reaches 1.
//      lu_hit is not re-evaluated while in LU_WAIT.
//  - Total bubbles per hazard = LOAD_LAT exactly.
//  - branch_taken in RUN/LU_WAIT: ifid_flush=1, pc_write=1, ifid_write=1, idex_bubble=1.
//      Any load-use stall is cancelled: lu_cnt cleared, next state RUN.
//  - mem_busy in any state: pipe_freeze=1, pc_write=ifid_write=idex_bubble=ifid_flush=0; state FREEZE.
//      lu_cnt holds its value; a pending flush waits, because branch_taken is held by the frozen EX.
//  - FREEZE, mem_busy=0: leave FREEZE in that same cycle.
//      Evaluate as LU_WAIT if lu_cnt!=0, otherwise as RUN.
//  - Counters: lu_stall_cnt +1 per cycle with idex_bubble & ~ifid_flush.
//      mem_stall_cnt +1 per cycle with pipe_freeze. Both saturate at 2^CNT_W-1.
//  - Reset (async, any time incl. mid-stall or mid-freeze): state RUN, lu_cnt=0, counters 0.
//      Outputs take the RUN/no-event values: pc_write=1, ifid_write=1, others 0.
//      A lu_hit present during reset still asserts the combinational stall.
// CONFIGURATION
//  HAZARD_STATS_EN defined: both stall counters are implemented.
//  HAZARD_STATS_EN undefined: no counter flops; lu_stall_cnt and mem_stall_cnt are tied to 0.
// TESTING
//  1) LOAD_LAT=1, load x5 in EX, ID reads rs1=x5 -> 1 cycle: pc_write=0, idex_bubble=1; then RUN.
//  2) LOAD_LAT=3, same hazard -> exactly 3 bubble cycles, lu_stall_cnt=3.
//     Same with idex_rd=0 -> no stall.
//  3) LOAD_LAT=3, branch_taken in 2nd bubble cycle -> ifid_flush=1, pc_write=1, stall cancelled, next cycle normal.
//  4) LOAD_LAT=3, mem_busy for 4 cycles starting in 2nd bubble -> pipe_freeze=1 for 4 cycles.
//     Then 2 remaining bubbles; mem_stall_cnt=4.
//  5) rst_n pulsed low in LU_WAIT -> outputs immediately pc_write=1, idex_bubble=0, counters 0.
//     Build without HAZARD_STATS_EN -> counters read 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Load-use hazard, memory-freeze and branch-flush controller
//                for the 5-stage core. Optional stall statistics counters are
//                built only when HAZARD_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_use_rs1,
    input  logic              ifid_use_rs2,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              pipe_freeze,
    output logic              stall,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  mem_stall_cnt
);

    localparam int                  c_lu_cnt_w  = $clog2(LOAD_LAT) + 1;
    localparam logic [c_lu_cnt_w-1:0] c_lu_reload = c_lu_cnt_w'(LOAD_LAT - 1);
    localparam logic [c_lu_cnt_w-1:0] c_lu_one    = c_lu_cnt_w'(1);

    localparam logic [1:0] c_st_run     = 2'd0;
    localparam logic [1:0] c_st_lu_wait = 2'd1;
    localparam logic [1:0] c_st_freeze  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_lu_cnt_w-1:0] r_lu_cnt;
    logic [c_lu_cnt_w-1:0] w_lu_cnt_nxt;

    logic w_lu_hit;
    logic w_in_wait;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_bubble;
    logic w_ifid_flush;
    logic w_pipe_freeze;

    // x0 is hard-wired to zero, so a load targeting it can never hazard.
    assign w_lu_hit = idex_memread && (idex_rd != '0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    // Leaving FREEZE resumes an interrupted load-use stall if bubbles remain.
    assign w_in_wait = (r_state == c_st_lu_wait) ||
                       ((r_state == c_st_freeze) && (r_lu_cnt != '0));

    always_comb begin
        w_state_nxt   = c_st_run;
        w_lu_cnt_nxt  = r_lu_cnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        w_pipe_freeze = 1'b0;

        if (mem_busy) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_pipe_freeze = 1'b1;
            w_state_nxt   = c_st_freeze;
        end else if (branch_taken) begin
            w_idex_bubble = 1'b1;
            w_ifid_flush  = 1'b1;
            w_lu_cnt_nxt  = '0;
            w_state_nxt   = c_st_run;
        end else if (w_in_wait) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            if (r_lu_cnt <= c_lu_one) begin
                w_lu_cnt_nxt = '0;
                w_state_nxt  = c_st_run;
            end else begin
                w_lu_cnt_nxt = r_lu_cnt - c_lu_one;
                w_state_nxt  = c_st_lu_wait;
            end
        end else if (w_lu_hit) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_lu_cnt_nxt  = c_lu_reload;
            w_state_nxt   = (c_lu_reload != '0) ? c_st_lu_wait : c_st_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_run;
            r_lu_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    assign pc_write    = w_pc_write;
    assign ifid_write  = w_ifid_write;
    assign idex_bubble = w_idex_bubble;
    assign ifid_flush  = w_ifid_flush;
    assign pipe_freeze = w_pipe_freeze;
    assign stall       = ~w_pc_write;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_lu_stall_cnt;
    logic [CNT_W-1:0] r_mem_stall_cnt;

    // Flush cycles also bubble ID/EX but are not load-use stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_stall_cnt  <= '0;
            r_mem_stall_cnt <= '0;
        end else begin
            if (w_idex_bubble && !w_ifid_flush && (r_lu_stall_cnt != '1))
                r_lu_stall_cnt <= r_lu_stall_cnt + CNT_W'(1);
            if (w_pipe_freeze && (r_mem_stall_cnt != '1))
                r_mem_stall_cnt <= r_mem_stall_cnt + CNT_W'(1);
        end
    end

    assign lu_stall_cnt  = r_lu_stall_cnt;
    assign mem_stall_cnt = r_mem_stall_cnt;
`else
    assign lu_stall_cnt  = '0;
    assign mem_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Directed-vector scoreboard bench for hazard_stall_ctrl with
//                LOAD_LAT=3 and LOAD_LAT=1 instances driven in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int c_reg_aw = 5;
    localparam int c_cnt_w  = 3;
    localparam int c_nvec   = 31;

    // Control vector bits: {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze, stall}
    localparam logic [5:0] c_norm = 6'b110000;
    localparam logic [5:0] c_stl  = 6'b001001;
    localparam logic [5:0] c_fls  = 6'b111100;
    localparam logic [5:0] c_frz  = 6'b000011;

    typedef struct packed {
        logic       rst_n;
        logic [2:0] hz;
        logic       br;
        logic       mb;
        logic [5:0] e3;
        logic [5:0] e1;
    } vec_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [5:0] ctl3;
        logic [5:0] ctl1;
        logic [2:0] lu3;
        logic [2:0] mem3;
        logic [2:0] lu1;
        logic [2:0] mem1;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                idex_memread;
    logic [c_reg_aw-1:0] idex_rd;
    logic [c_reg_aw-1:0] ifid_rs1;
    logic [c_reg_aw-1:0] ifid_rs2;
    logic                ifid_use_rs1;
    logic                ifid_use_rs2;
    logic                branch_taken;
    logic                mem_busy;

    logic pw3, iw3, bub3, fl3, frz3, st3;
    logic pw1, iw1, bub1, fl1, frz1, st1;
    logic [c_cnt_w-1:0] lu3, mem3, lu1, mem1;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    hazard_stall_ctrl #(.REG_AW(c_reg_aw), .LOAD_LAT(3), .CNT_W(c_cnt_w)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pw3), .ifid_write(iw3), .idex_bubble(bub3),
        .ifid_flush(fl3), .pipe_freeze(frz3), .stall(st3),
        .lu_stall_cnt(lu3), .mem_stall_cnt(mem3)
    );

    hazard_stall_ctrl #(.REG_AW(c_reg_aw), .LOAD_LAT(1), .CNT_W(c_cnt_w)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pw1), .ifid_write(iw1), .idex_bubble(bub1),
        .ifid_flush(fl1), .pipe_freeze(frz1), .stall(st1),
        .lu_stall_cnt(lu1), .mem_stall_cnt(mem1)
    );

    // 0 none, 1 rs1 hit on x5, 2 load to x0, 3 rs2 hit on x7, 4 load with no used match
    task automatic set_hz(input logic [2:0] id);
        case (id)
            3'd1:    begin idex_memread = 1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs2 = 5'd0; ifid_use_rs1 = 1; ifid_use_rs2 = 0; end
            3'd2:    begin idex_memread = 1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd3; ifid_use_rs1 = 1; ifid_use_rs2 = 1; end
            3'd3:    begin idex_memread = 1; idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_rs2 = 5'd7; ifid_use_rs1 = 0; ifid_use_rs2 = 1; end
            3'd4:    begin idex_memread = 1; idex_rd = 5'd5; ifid_rs1 = 5'd6; ifid_rs2 = 5'd5; ifid_use_rs1 = 1; ifid_use_rs2 = 0; end
            default: begin idex_memread = 0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_use_rs1 = 0; ifid_use_rs2 = 0; end
        endcase
    endtask

    function automatic logic [2:0] sat_inc(input logic [2:0] x, input logic en);
        return (en && (x != 3'd7)) ? x + 3'd1 : x;
    endfunction

    initial begin : p_stim
        vec_t       vt [c_nvec];
        exp_t       e;
        logic [2:0] r_lu3, r_mem3, r_lu1, r_mem1;

        //            rst   hz    br    mb    dut3    dut1
        vt[0]  = '{1'b0, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[1]  = '{1'b0, 3'd1, 1'b0, 1'b0, c_stl,  c_stl };
        vt[2]  = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[3]  = '{1'b1, 3'd1, 1'b0, 1'b0, c_stl,  c_stl };
        vt[4]  = '{1'b1, 3'd0, 1'b0, 1'b0, c_stl,  c_norm};
        vt[5]  = '{1'b1, 3'd0, 1'b0, 1'b0, c_stl,  c_norm};
        vt[6]  = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[7]  = '{1'b1, 3'd2, 1'b0, 1'b0, c_norm, c_norm};
        vt[8]  = '{1'b1, 3'd4, 1'b0, 1'b0, c_norm, c_norm};
        vt[9]  = '{1'b1, 3'd3, 1'b0, 1'b0, c_stl,  c_stl };
        vt[10] = '{1'b1, 3'd0, 1'b1, 1'b0, c_fls,  c_fls };
        vt[11] = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[12] = '{1'b1, 3'd1, 1'b0, 1'b0, c_stl,  c_stl };
        vt[13] = '{1'b1, 3'd0, 1'b0, 1'b1, c_frz,  c_frz };
        vt[14] = '{1'b1, 3'd0, 1'b0, 1'b1, c_frz,  c_frz };
        vt[15] = '{1'b1, 3'd0, 1'b0, 1'b1, c_frz,  c_frz };
        vt[16] = '{1'b1, 3'd0, 1'b0, 1'b1, c_frz,  c_frz };
        vt[17] = '{1'b1, 3'd0, 1'b0, 1'b0, c_stl,  c_norm};
        vt[18] = '{1'b1, 3'd0, 1'b0, 1'b0, c_stl,  c_norm};
        vt[19] = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[20] = '{1'b1, 3'd0, 1'b1, 1'b1, c_frz,  c_frz };
        vt[21] = '{1'b1, 3'd0, 1'b1, 1'b0, c_fls,  c_fls };
        vt[22] = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[23] = '{1'b1, 3'd1, 1'b1, 1'b0, c_fls,  c_fls };
        vt[24] = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[25] = '{1'b1, 3'd1, 1'b0, 1'b1, c_frz,  c_frz };
        vt[26] = '{1'b1, 3'd1, 1'b0, 1'b0, c_stl,  c_stl };
        vt[27] = '{1'b1, 3'd0, 1'b0, 1'b0, c_stl,  c_norm};
        vt[28] = '{1'b0, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[29] = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};
        vt[30] = '{1'b1, 3'd0, 1'b0, 1'b0, c_norm, c_norm};

        rst_n        = 1'b0;
        branch_taken = 1'b0;
        mem_busy     = 1'b0;
        set_hz(3'd0);
        r_lu3 = '0; r_mem3 = '0; r_lu1 = '0; r_mem1 = '0;

        for (int k = 0; k < c_nvec; k++) begin
            @(posedge clk);
            #1;
            rst_n        = vt[k].rst_n;
            branch_taken = vt[k].br;
            mem_busy     = vt[k].mb;
            set_hz(vt[k].hz);

            if (!vt[k].rst_n) begin
                r_lu3 = '0; r_mem3 = '0; r_lu1 = '0; r_mem1 = '0;
            end
            e.idx  = 8'(k);
            e.ctl3 = vt[k].e3;
            e.ctl1 = vt[k].e1;
`ifdef HAZARD_STATS_EN
            e.lu3 = r_lu3; e.mem3 = r_mem3; e.lu1 = r_lu1; e.mem1 = r_mem1;
`else
            e.lu3 = '0; e.mem3 = '0; e.lu1 = '0; e.mem1 = '0;
`endif
            sb_q.push_back(e);

            // Counters capture this cycle's stall at the next edge.
            if (vt[k].rst_n) begin
                r_lu3  = sat_inc(r_lu3,  vt[k].e3[3] & ~vt[k].e3[2]);
                r_mem3 = sat_inc(r_mem3, vt[k].e3[1]);
                r_lu1  = sat_inc(r_lu1,  vt[k].e1[3] & ~vt[k].e1[2]);
                r_mem1 = sat_inc(r_mem1, vt[k].e1[1]);
            end
        end

        for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(posedge clk);
        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
            n_err++;
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : p_monitor
        exp_t       e;
        logic [5:0] a3, a1;
        logic       bad;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e   = sb_q.pop_front();
                a3  = {pw3, iw3, bub3, fl3, frz3, st3};
                a1  = {pw1, iw1, bub1, fl1, frz1, st1};
                bad = 1'b0;
                n_vec++;
                if (a3 !== e.ctl3) begin
                    $display("FAIL vec%0d ctl_lat3 got=%b required=%b", e.idx, a3, e.ctl3); bad = 1'b1;
                end
                if (a1 !== e.ctl1) begin
                    $display("FAIL vec%0d ctl_lat1 got=%b required=%b", e.idx, a1, e.ctl1); bad = 1'b1;
                end
                if ({lu3, mem3} !== {e.lu3, e.mem3}) begin
                    $display("FAIL vec%0d cnt_lat3 got lu=%0d mem=%0d required lu=%0d mem=%0d",
                             e.idx, lu3, mem3, e.lu3, e.mem3); bad = 1'b1;
                end
                if ({lu1, mem1} !== {e.lu1, e.mem1}) begin
                    $display("FAIL vec%0d cnt_lat1 got lu=%0d mem=%0d required lu=%0d mem=%0d",
                             e.idx, lu1, mem1, e.lu1, e.mem1); bad = 1'b1;
                end
                if (bad) n_err++;
            end
        end
    end

endmodule
`default_nettype wire
